// File: rtl/regfile_mp.sv
// Dual-write, dual-read register file with a per-register busy scoreboard and optional zero register.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data onto the read buses.
module regfile_mp #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter int ZERO_EN = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic              BusyA,
    output logic              BusyB,
    input  logic              RegWr0,
    input  logic              RegWr1,
    input  logic [ADDR_W-1:0] RW0,
    input  logic [ADDR_W-1:0] RW1,
    input  logic [DATA_W-1:0] BusW0,
    input  logic [DATA_W-1:0] BusW1,
    input  logic              Claim,
    input  logic [ADDR_W-1:0] ClaimReg,
    output logic              WrConflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              we0;
    logic              we1;
    logic              claim_en;
    logic              wr_conflict_q;

    function automatic logic is_zr(input logic [ADDR_W-1:0] idx);
        return (ZERO_EN != 0) && (idx == {ADDR_W{1'b1}});
    endfunction

    // Only an X-propagating simulator can see an unknown index; synthesis folds this to 0.
    function automatic logic idx_x(input logic [ADDR_W-1:0] idx);
        return (^idx) === 1'bx;
    endfunction

    always_comb begin
        we0      = RegWr0 && !idx_x(RW0) && !is_zr(RW0);
        we1      = RegWr1 && !idx_x(RW1) && !is_zr(RW1);
        claim_en = Claim && !idx_x(ClaimReg) && !is_zr(ClaimReg);
    end

    // Writes clear busy first so a same-cycle claim on the same register leaves it set.
    always_comb begin
        busy_nxt = busy;
        if (we0)      busy_nxt[RW0]      = 1'b0;
        if (we1)      busy_nxt[RW1]      = 1'b0;
        if (claim_en) busy_nxt[ClaimReg] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regs          <= '{default: '0};
            busy          <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            if (we0) regs[RW0] <= BusW0;
            if (we1) regs[RW1] <= BusW1;
            busy          <= busy_nxt;
            wr_conflict_q <= we0 && we1 && (RW0 == RW1);
        end
    end

    assign WrConflict = wr_conflict_q;

    always_comb begin
        BusA  = '0;
        BusB  = '0;
        BusyA = 1'b0;
        BusyB = 1'b0;
        if (!idx_x(RA) && !is_zr(RA)) begin
            BusA  = regs[RA];
            BusyA = busy[RA];
`ifdef REGFILE_MP_BYPASS_EN
            if (Rst_n && we1 && (RW1 == RA))      BusA = BusW1;
            else if (Rst_n && we0 && (RW0 == RA)) BusA = BusW0;
`endif
        end
        if (!idx_x(RB) && !is_zr(RB)) begin
            BusB  = regs[RB];
            BusyB = busy[RB];
`ifdef REGFILE_MP_BYPASS_EN
            if (Rst_n && we1 && (RW1 == RB))      BusB = BusW1;
            else if (Rst_n && we0 && (RW0 == RB)) BusB = BusW0;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 64x32 instance with zero register plus a 32x16 instance without.
module tb_regfile_mp;

    logic        Clk;
    logic        Rst_n;

    logic [4:0]  RA, RB, RW0, RW1, ClaimReg;
    logic [63:0] BusA, BusB, BusW0, BusW1;
    logic        BusyA, BusyB, RegWr0, RegWr1, Claim, WrConflict;

    logic [3:0]  p_RA, p_RB, p_RW0, p_RW1, p_ClaimReg;
    logic [31:0] p_BusA, p_BusB, p_BusW0, p_BusW1;
    logic        p_BusyA, p_BusyB, p_RegWr0, p_RegWr1, p_Claim, p_WrConflict;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_checks;
    int       n_fail;

    regfile_mp u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
        .BusyA(BusyA), .BusyB(BusyB), .RegWr0(RegWr0), .RegWr1(RegWr1),
        .RW0(RW0), .RW1(RW1), .BusW0(BusW0), .BusW1(BusW1),
        .Claim(Claim), .ClaimReg(ClaimReg), .WrConflict(WrConflict)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .ZERO_EN(0)) u_p (
        .Clk(Clk), .Rst_n(Rst_n), .RA(p_RA), .RB(p_RB), .BusA(p_BusA), .BusB(p_BusB),
        .BusyA(p_BusyA), .BusyB(p_BusyB), .RegWr0(p_RegWr0), .RegWr1(p_RegWr1),
        .RW0(p_RW0), .RW1(p_RW1), .BusW0(p_BusW0), .BusW1(p_BusW1),
        .Claim(p_Claim), .ClaimReg(p_ClaimReg), .WrConflict(p_WrConflict)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [63:0] val);
        sb_item_t it;
        it.tag = tag;
        it.val = val;
        sb_q.push_back(it);
    endtask

    task automatic check_pop(input logic [63:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: observed 0x%0h with no expectation queued", obs);
        end else begin
            it = sb_q.pop_front();
            check(it.tag, obs, it.val);
        end
    endtask

    task automatic idle();
        RegWr0 = 0; RegWr1 = 0; RW0 = '0; RW1 = '0; BusW0 = '0; BusW1 = '0;
        Claim = 0; ClaimReg = '0;
        p_RegWr0 = 0; p_RegWr1 = 0; p_RW0 = '0; p_RW1 = '0; p_BusW0 = '0; p_BusW1 = '0;
        p_Claim = 0; p_ClaimReg = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        RA = 5'd3; RB = 5'd7; p_RA = 4'd0; p_RB = 4'd15;
        Rst_n = 1'b0;

        // Reset state
        expect_val("rst_busa", 64'h0);
        expect_val("rst_busya", 64'h0);
        expect_val("rst_wrconflict", 64'h0);
        expect_val("rst_p_busb", 64'h0);
        #2;
        check_pop(BusA);
        check_pop({63'h0, BusyA});
        check_pop({63'h0, WrConflict});
        check_pop({32'h0, p_BusB});
        tick();
        Rst_n = 1'b1;
        tick();

        // Dual write X3 leaves X3=0x1234 and raises WrConflict; mid-cycle reset clears both
        RegWr0 = 1; RW0 = 5'd3; BusW0 = 64'h1111;
        RegWr1 = 1; RW1 = 5'd3; BusW1 = 64'h1234;
        tick();
        idle();
        RA = 5'd3;
        expect_val("x3_pre_reset", 64'h1234);
        expect_val("x3_conflict", 64'h1);
        #1;
        check_pop(BusA);
        check_pop({63'h0, WrConflict});
        Rst_n = 1'b0;
        expect_val("x3_async_reset", 64'h0);
        expect_val("conflict_async_reset", 64'h0);
        #1;
        check_pop(BusA);
        check_pop({63'h0, WrConflict});
        tick();
        Rst_n = 1'b1;
        tick();

        // Port 1 wins on same-register dual write; conflict flag lasts one cycle
        RegWr0 = 1; RW0 = 5'd7; BusW0 = 64'hAAAA;
        RegWr1 = 1; RW1 = 5'd7; BusW1 = 64'h5555;
        tick();
        idle();
        RA = 5'd7;
        expect_val("x7_port1_wins", 64'h5555);
        expect_val("conflict_set", 64'h1);
        #1;
        check_pop(BusA);
        check_pop({63'h0, WrConflict});
        tick();
        expect_val("conflict_one_cycle", 64'h0);
        check_pop({63'h0, WrConflict});

        // Different-register dual write: no conflict, both committed
        RegWr0 = 1; RW0 = 5'd8; BusW0 = 64'hCAFE_0008;
        RegWr1 = 1; RW1 = 5'd9; BusW1 = 64'hCAFE_0009;
        tick();
        idle();
        RA = 5'd8; RB = 5'd9;
        expect_val("x8_written", 64'hCAFE_0008);
        expect_val("x9_written", 64'hCAFE_0009);
        expect_val("no_conflict_diff", 64'h0);
        #1;
        check_pop(BusA);
        check_pop(BusB);
        check_pop({63'h0, WrConflict});

        // Zero register: writes and claims ignored, dual write gives no conflict
        RegWr0 = 1; RW0 = 5'd31; BusW0 = 64'hFFFF;
        RegWr1 = 1; RW1 = 5'd31; BusW1 = 64'hFFFF;
        Claim = 1; ClaimReg = 5'd31;
        tick();
        idle();
        RA = 5'd31;
        expect_val("zr_busa", 64'h0);
        expect_val("zr_busya", 64'h0);
        expect_val("zr_no_conflict", 64'h0);
        #1;
        check_pop(BusA);
        check_pop({63'h0, BusyA});
        check_pop({63'h0, WrConflict});

        // Scoreboard: claim is not visible before the edge, set after it
        Claim = 1; ClaimReg = 5'd4; RA = 5'd4;
        expect_val("busy_no_bypass", 64'h0);
        #1;
        check_pop({63'h0, BusyA});
        tick();
        idle();
        expect_val("busy_after_claim", 64'h1);
        #1;
        check_pop({63'h0, BusyA});
        RegWr0 = 1; RW0 = 5'd4; BusW0 = 64'h99;
        tick();
        idle();
        expect_val("busy_cleared_w0", 64'h0);
        expect_val("x4_data", 64'h99);
        #1;
        check_pop({63'h0, BusyA});
        check_pop(BusA);

        // Claim and write to X5 in the same cycle: claim wins, data still committed
        Claim = 1; ClaimReg = 5'd5;
        RegWr1 = 1; RW1 = 5'd5; BusW1 = 64'h77;
        tick();
        idle();
        RB = 5'd5;
        expect_val("busy_claim_wins", 64'h1);
        expect_val("x5_data", 64'h77);
        #1;
        check_pop({63'h0, BusyB});
        check_pop(BusB);

        // Port 1 write also clears busy
        Claim = 1; ClaimReg = 5'd6;
        tick();
        idle();
        RegWr1 = 1; RW1 = 5'd6; BusW1 = 64'h66;
        tick();
        idle();
        RA = 5'd6;
        expect_val("busy_cleared_w1", 64'h0);
        #1;
        check_pop({63'h0, BusyA});

        // Bypass vs array-only read
        RegWr0 = 1; RW0 = 5'd2; BusW0 = 64'h1;
        tick();
        idle();
        RA = 5'd2;
        RegWr0 = 1; RW0 = 5'd2; BusW0 = 64'h42;
`ifdef REGFILE_MP_BYPASS_EN
        expect_val("bypass_w0", 64'h42);
`else
        expect_val("no_bypass_w0", 64'h1);
`endif
        #1;
        check_pop(BusA);
        RegWr1 = 1; RW1 = 5'd2; BusW1 = 64'h43;
`ifdef REGFILE_MP_BYPASS_EN
        expect_val("bypass_w1_priority", 64'h43);
`else
        expect_val("no_bypass_w1", 64'h1);
`endif
        #1;
        check_pop(BusA);
        tick();
        idle();
        expect_val("x2_after_edge", 64'h43);
        #1;
        check_pop(BusA);

        // Parametrised instance: walking ones through every register, even on port 0, odd on port 1
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                p_RegWr0 = 1; p_RW0 = 4'(i); p_BusW0 = 32'h1 << (2 * i);
            end else begin
                p_RegWr1 = 1; p_RW1 = 4'(i); p_BusW1 = 32'h1 << (2 * i);
            end
            expect_val($sformatf("p_walk_x%0d", i), 64'(32'h1 << (2 * i)));
            tick();
            idle();
        end
        for (int i = 0; i < 16; i++) begin
            p_RB = 4'(i);
            #1;
            check_pop({32'h0, p_BusB});
        end

        p_RegWr0 = 1; p_RW0 = 4'd15; p_BusW0 = 32'h1111_1111;
        p_RegWr1 = 1; p_RW1 = 4'd15; p_BusW1 = 32'hDEAD_BEEF;
        tick();
        idle();
        p_RA = 4'd15;
        expect_val("p_x15", 64'hDEAD_BEEF);
        expect_val("p_x15_conflict", 64'h1);
        #1;
        check_pop({32'h0, p_BusA});
        check_pop({63'h0, p_WrConflict});

        p_Claim = 1; p_ClaimReg = 4'd15;
        tick();
        idle();
        expect_val("p_x15_busy", 64'h1);
        #1;
        check_pop({63'h0, p_BusyA});

        check("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
